// File: rtl/oh_mux_rr.sv
// oh_mux_rr: M-input, N-bit round-robin arbitrating mux with one registered output stage.
// Optional packet lock is enabled by defining OH_MUX_RR_LOCK_EN (adds port last_in).
module oh_mux_rr #(
    parameter int N = 1,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [M-1:0]   valid_in,
    input  logic [M*N-1:0] data_in,
    output logic [M-1:0]   ready_out,
`ifdef OH_MUX_RR_LOCK_EN
    input  logic [M-1:0]   last_in,
`endif
    output logic           valid_out,
    output logic [N-1:0]   data_out,
    output logic [M-1:0]   sel_out,
    input  logic           ready_in
);

    localparam int IW = $clog2(M);

    logic [IW-1:0] ptr_r;
    logic [M-1:0]  rr_grant_s;
    logic [IW-1:0] rr_idx_s;
    logic          rr_found_s;
    logic [M-1:0]  grant_s;
    logic [IW-1:0] win_idx_s;
    logic [N-1:0]  win_data_s;
    logic          load_s;
    logic          accept_s;

`ifdef OH_MUX_RR_LOCK_EN
    logic          lock_r;
    logic [IW-1:0] lock_idx_r;
`endif

    // Round-robin search starting just after the last winner, wrapping at M-1 -> 0.
    always_comb begin : rr_search
        int idx;
        idx        = 0;
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        for (int k = 1; k <= M; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= M) begin
                idx = idx - M;
            end else begin
                idx = idx;
            end
            if (!rr_found_s && valid_in[idx]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = IW'(idx);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        if (rr_found_s) begin
            rr_grant_s = {{(M-1){1'b0}}, 1'b1} << rr_idx_s;
        end else begin
            rr_grant_s = '0;
        end
    end

    // Final grant: a locked packet owner overrides the round robin.
    always_comb begin
        grant_s   = rr_grant_s;
        win_idx_s = rr_idx_s;
`ifdef OH_MUX_RR_LOCK_EN
        if (lock_r) begin
            win_idx_s = lock_idx_r;
            if (valid_in[lock_idx_r]) begin
                grant_s = {{(M-1){1'b0}}, 1'b1} << lock_idx_r;
            end else begin
                grant_s = '0;
            end
        end else begin
            grant_s = rr_grant_s;
        end
`endif
    end

    // Handshake: ready depends only on grant and output-register availability, never on data.
    always_comb begin
        load_s     = ~valid_out | ready_in;
        ready_out  = grant_s & {M{load_s & ~reset}};
        accept_s   = |ready_out;
        win_data_s = data_in[int'(win_idx_s)*N +: N];
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_out   <= '0;
            ptr_r     <= IW'(M - 1);
        end else if (accept_s) begin
            valid_out <= 1'b1;
            data_out  <= win_data_s;
            sel_out   <= grant_s;
            ptr_r     <= win_idx_s;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_out;
        end
    end

`ifdef OH_MUX_RR_LOCK_EN
    // Packet lock: set by a non-last beat, released by the owner's last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
        end else if (accept_s) begin
            if (lock_r) begin
                if (last_in[win_idx_s]) begin
                    lock_r <= 1'b0;
                end else begin
                    lock_r <= 1'b1;
                end
            end else if (!last_in[win_idx_s]) begin
                lock_r     <= 1'b1;
                lock_idx_r <= win_idx_s;
            end else begin
                lock_r <= 1'b0;
            end
        end else begin
            lock_r <= lock_r;
        end
    end
`endif

endmodule

// File: tb/tb_oh_mux_rr.sv
// Directed self-checking bench for oh_mux_rr (M=4 and M=3 instances, N=8).
module tb_oh_mux_rr;

    logic        clk;
    logic        reset;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic [3:0]  ready_out;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [3:0]  sel_out;
    logic        ready_in;
`ifdef OH_MUX_RR_LOCK_EN
    logic [3:0]  last_in;
`endif

    logic [2:0]  valid3;
    logic [23:0] data3;
    logic [2:0]  ready3;
    logic        vout3;
    logic [7:0]  dout3;
    logic [2:0]  sel3;
    logic        rin3;

    int n_tests = 0;
    int n_fail  = 0;

    oh_mux_rr #(.N(8), .M(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out),
`ifdef OH_MUX_RR_LOCK_EN
        .last_in(last_in),
`endif
        .valid_out(valid_out), .data_out(data_out), .sel_out(sel_out),
        .ready_in(ready_in)
    );

    oh_mux_rr #(.N(8), .M(3)) dut3 (
        .clk(clk), .reset(reset), .valid_in(valid3), .data_in(data3),
        .ready_out(ready3),
`ifdef OH_MUX_RR_LOCK_EN
        .last_in(3'b111),
`endif
        .valid_out(vout3), .data_out(dout3), .sel_out(sel3),
        .ready_in(rin3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        reset    = 1'b1;
        valid_in = 4'b0000;
        data_in  = 32'h0;
        ready_in = 1'b1;
        valid3   = 3'b000;
        data3    = 24'h0;
        rin3     = 1'b1;
`ifdef OH_MUX_RR_LOCK_EN
        last_in  = 4'b1111;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        check_eq("rst_data", 32'(data_out), 32'h0);
        check_eq("rst_sel", 32'(sel_out), 32'h0);
        reset = 1'b0;

        // All channels valid: rotation 0,1,2,3,0
        valid_in = 4'b1111;
        data_in  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        check_eq("rr_first_ready", 32'(ready_out), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rr_sel", 32'(sel_out), 32'h1 << (k % 4));
            check_eq("rr_data", 32'(data_out), 32'h10 + 32'(k % 4));
            check_eq("rr_valid", 32'(valid_out), 32'h1);
        end

        // Lone requester ch2 served every cycle
        for (int k = 0; k < 3; k++) begin
            d = 8'hA0 + 8'(k);
            valid_in = 4'b0100;
            data_in  = {8'h13, d, 8'h11, 8'h10};
            #1;
            check_eq("lone_ready", 32'(ready_out), 32'h4);
            tick();
            check_eq("lone_data", 32'(data_out), 32'(d));
            check_eq("lone_sel", 32'(sel_out), 32'h4);
        end

        // Stall, then release without a bubble
        ready_in = 1'b0;
        valid_in = 4'b0011;
        data_in  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        check_eq("stall_ready", 32'(ready_out), 32'h0);
        tick();
        tick();
        check_eq("stall_data", 32'(data_out), 32'hA2);
        check_eq("stall_sel", 32'(sel_out), 32'h4);
        check_eq("stall_valid", 32'(valid_out), 32'h1);
        ready_in = 1'b1;
        #1;
        check_eq("resume_ready", 32'(ready_out), 32'h1);
        tick();
        check_eq("resume_sel", 32'(sel_out), 32'h1);
        check_eq("resume_data", 32'(data_out), 32'h10);
        check_eq("resume_valid", 32'(valid_out), 32'h1);
        check_eq("resume_next_ready", 32'(ready_out), 32'h2);
        tick();
        check_eq("resume_sel2", 32'(sel_out), 32'h2);
        check_eq("resume_data2", 32'(data_out), 32'h11);

        // Drain: valid drops, data and sel hold
        valid_in = 4'b0000;
        #1;
        check_eq("drain_ready", 32'(ready_out), 32'h0);
        tick();
        check_eq("drain_valid", 32'(valid_out), 32'h0);
        check_eq("drain_data", 32'(data_out), 32'h11);
        check_eq("drain_sel", 32'(sel_out), 32'h2);

        // Reset mid-transfer
        valid_in = 4'b1111;
        tick();
        check_eq("pre_rst_valid", 32'(valid_out), 32'h1);
        check_eq("pre_rst_sel", 32'(sel_out), 32'h4);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(valid_out), 32'h0);
        check_eq("mid_rst_sel", 32'(sel_out), 32'h0);
        check_eq("mid_rst_ready", 32'(ready_out), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(ready_out), 32'h1);
        tick();
        check_eq("post_rst_sel", 32'(sel_out), 32'h1);
        valid_in = 4'b0000;

        // M=3 wrap: ptr=2 -> ch0, then ptr=0 -> ch2
        valid3 = 3'b101;
        data3  = {8'h32, 8'h31, 8'h30};
        #1;
        check_eq("m3_first_ready", 32'(ready3), 32'h1);
        tick();
        check_eq("m3_sel0", 32'(sel3), 32'h1);
        check_eq("m3_data0", 32'(dout3), 32'h30);
        check_eq("m3_second_ready", 32'(ready3), 32'h4);
        tick();
        check_eq("m3_sel2", 32'(sel3), 32'h4);
        check_eq("m3_data2", 32'(dout3), 32'h32);
        valid3 = 3'b000;

`ifdef OH_MUX_RR_LOCK_EN
        // Packet lock: ch1 three beats with a gap, ch0/ch2 competing
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_in  = 4'b1101;
        valid_in = 4'b0010;
        data_in  = {8'h13, 8'h12, 8'hB1, 8'h10};
        #1;
        check_eq("lk_b1_ready", 32'(ready_out), 32'h2);
        tick();
        check_eq("lk_b1_data", 32'(data_out), 32'hB1);
        valid_in = 4'b0111;
        data_in  = {8'h13, 8'h12, 8'hB2, 8'h10};
        #1;
        check_eq("lk_b2_ready", 32'(ready_out), 32'h2);
        tick();
        check_eq("lk_b2_data", 32'(data_out), 32'hB2);
        valid_in = 4'b0101;
        #1;
        check_eq("lk_gap_ready", 32'(ready_out), 32'h0);
        tick();
        check_eq("lk_gap_valid", 32'(valid_out), 32'h0);
        last_in  = 4'b1111;
        valid_in = 4'b0111;
        data_in  = {8'h13, 8'h12, 8'hB3, 8'h10};
        #1;
        check_eq("lk_b3_ready", 32'(ready_out), 32'h2);
        tick();
        check_eq("lk_b3_data", 32'(data_out), 32'hB3);
        check_eq("lk_after_ready", 32'(ready_out), 32'h4);
        valid_in = 4'b0000;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
